// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the 4-bit mux-based shift datapath: captures an operand,
// mode and step count on START, then applies one shift/rotate step per unstalled clock.
module shift_seq_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       DIN,
  input  logic [1:0]       MODE,
  input  logic [CNT_W-1:0] COUNT,
  input  logic             STALL,
  output logic [3:0]       DOUT,
  output logic [1:0]       SEL,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       mode_q;
  logic [3:0]       dout_q;
  logic [1:0]       sel_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       step_d;

  // One datapath step: the same function the combinational shifter computes for SEL.
  function automatic logic [3:0] shift_step(input logic [3:0] d, input logic [1:0] m);
    logic [3:0] r;
    case (m)
      2'b00:   r = d;
      2'b01:   r = {d[2:0], 1'b1};
      2'b10:   r = {1'b1, d[3:1]};
      2'b11:   r = {d[0], d[3:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Next working value if the current cycle advances a step.
  always_comb begin
    step_d = shift_step(dout_q, mode_q);
  end

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      rem_q   <= {CNT_W{1'b0}};
      mode_q  <= 2'b00;
      dout_q  <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            dout_q <= DIN;
            mode_q <= MODE;
            rem_q  <= COUNT;
            if (COUNT != {CNT_W{1'b0}}) begin
              state_q <= ST_SHIFT;
              sel_q   <= MODE;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Zero-step request completes immediately without touching the datapath.
              state_q <= ST_FINISH;
              sel_q   <= 2'b00;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!STALL) begin
            dout_q <= step_d;
            rem_q  <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= ST_FINISH;
              sel_q   <= 2'b00;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              sel_q   <= mode_q;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_SHIFT;
            sel_q   <= mode_q;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          sel_q   <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          rem_q   <= {CNT_W{1'b0}};
          sel_q   <= 2'b00;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DOUT = dout_q;
  assign SEL  = sel_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
